// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO: width functions sized from DEPTH
// and the per-cycle operation encoding used by the occupancy logic.
package fifo_pkg;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // {write accepted, read accepted}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array with a gated write port and a registered,
// enabled read port.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM; only the output register is reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // NOTE: sequential state always uses non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Parametrised single-clock FIFO with count-based occupancy, registered flags,
// synchronous flush and sticky overflow/underflow errors.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  ptr_t wptr, rptr;
  cnt_t count_next;
  logic wr_acc, rd_acc;
  op_e  op;

  // Acceptance uses this cycle's registered flags; a flush suppresses both ports.
  assign wr_acc = wr_en & ~full  & ~clear;
  assign rd_acc = rd_en & ~empty & ~clear;
  assign op     = op_e'({wr_acc, rd_acc});

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wptr),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rptr),
    .rd_data (rd_data)
  );

  // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else begin
      unique case (op)
        OP_WR:   count_next = count + cnt_t'(1);
        OP_RD:   count_next = count - cnt_t'(1);
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      rd_valid     <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (clear) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_acc) wptr <= wptr + ptr_t'(1);
        if (rd_acc) rptr <= rptr + ptr_t'(1);
      end
      // Flags come from the next count so they always agree with count.
      count        <= count_next;
      full         <= (count_next == cnt_t'(DEPTH));
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= cnt_t'(AF_LEVEL));
      almost_empty <= (count_next <= cnt_t'(AE_LEVEL));
      rd_valid     <= rd_acc;
      overflow     <= ~clear & (overflow  | (wr_en & full));
      underflow    <= ~clear & (underflow | (rd_en & empty));
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a reference model with a scoreboard queue
// predicts data, count, flags and error bits after every clock edge.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AFL   = DEPTH - 2;
  localparam int AEL   = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full, empty, almost_full, almost_empty;
  logic [3:0]    count;
  logic          overflow, underflow;

  int errors = 0;
  int checks = 0;

  // Reference model
  logic [DW-1:0] sb [$];
  int            m_count;
  logic          m_ovf, m_udf, m_valid;
  logic [DW-1:0] m_rd;

  sync_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AFL),
    .AE_LEVEL   (AEL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ":rd_valid"},     32'(rd_valid),     32'(m_valid));
    check({ctx, ":rd_data"},      32'(rd_data),      32'(m_rd));
    check({ctx, ":count"},        32'(count),        32'(m_count));
    check({ctx, ":full"},         32'(full),         32'(m_count == DEPTH));
    check({ctx, ":empty"},        32'(empty),        32'(m_count == 0));
    check({ctx, ":almost_full"},  32'(almost_full),  32'(m_count >= AFL));
    check({ctx, ":almost_empty"}, 32'(almost_empty), 32'(m_count <= AEL));
    check({ctx, ":overflow"},     32'(overflow),     32'(m_ovf));
    check({ctx, ":underflow"},    32'(underflow),    32'(m_udf));
  endtask

  task automatic model_reset();
    sb.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_valid = 1'b0;
    m_rd    = '0;
  endtask

  // Drive one cycle of stimulus, advance the model, then check just after the edge.
  task automatic step(input string ctx, input logic w, input logic [DW-1:0] d,
                      input logic r, input logic c);
    logic wa, ra;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    clear   = c;
    wa = w && (m_count < DEPTH) && !c;
    ra = r && (m_count > 0) && !c;
    if (wa) sb.push_back(d);
    @(posedge clk);
    #1;
    m_valid = ra;
    if (ra) m_rd = sb.pop_front();
    if (c) begin
      sb.delete();
      m_count = 0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      if (w && m_count == DEPTH) m_ovf = 1'b1;
      if (r && m_count == 0)     m_udf = 1'b1;
      m_count = m_count + int'(wa) - int'(ra);
    end
    check_all(ctx);
  endtask

  initial begin
    rst_n   = 1'b0;
    clear   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill with 0x11..0x18, then overflow attempt with 0xAA.
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
    step("ovf_wr", 1'b1, 8'hAA, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
    step("idle", 1'b0, '0, 1'b0, 1'b0);

    // Underflow on empty, then flush clears both error flags.
    step("udf_rd", 1'b0, '0, 1'b1, 1'b0);
    step("clear1", 1'b0, '0, 1'b0, 1'b1);

    // Hold count at 4 with simultaneous traffic; pointers wrap several times.
    for (int i = 0; i < 4; i++)  step("pre4", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step("both4", 1'b1, 8'(8'h30 + i), 1'b1, 1'b0);

    // From full, simultaneous request: read wins, write rejected.
    for (int i = 0; i < 4; i++) step("top8", 1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    step("both_full", 1'b1, 8'hBB, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step("drain7", 1'b0, '0, 1'b1, 1'b0);

    // From empty, simultaneous request: write wins, read rejected.
    step("both_empty", 1'b1, 8'hCC, 1'b1, 1'b0);
    step("rd_cc", 1'b0, '0, 1'b1, 1'b0);
    step("clear2", 1'b0, '0, 1'b0, 1'b1);

    // Flush has priority over concurrent write and read.
    for (int i = 0; i < 5; i++) step("pre5", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step("clr_prio", 1'b1, 8'hDD, 1'b1, 1'b1);
    step("post_clr", 1'b1, 8'h70, 1'b0, 1'b0);
    step("post_rd", 1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 3; i++) step("burst", 1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
    wr_en   = 1'b1;
    wr_data = 8'h99;
    rd_en   = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step("after_rst", 1'b1, 8'h42, 1'b0, 1'b0);
    step("after_rd", 1'b0, '0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
